// File: rtl/qam_symbol_sched.sv
// Symbol scheduler and bit packer for the scale-QAM mapper: slices a byte stream
// into per-symbol I/Q bit groups and strobes the mapper once per symbol period.
module qam_symbol_sched #(
  parameter int SYM_DIV    = 4,
  parameter int FRAME_SYMS = 64
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [2:0]  cfg_modi,
  input  logic        cfg_run,
  output logic [11:0] sym_data,
  output logic [2:0]  sym_modi,
  output logic        sym_en,
  output logic        frame_start,
  output logic        underrun,
  output logic        busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [15:0] DIV_LAST   = 16'(SYM_DIV - 1);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_SYMS - 1);
  localparam logic [2:0]  MODI_NULL  = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  act_modi_q, act_modi_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] sym_data_q, sym_data_d;
  logic [2:0]  sym_modi_q, sym_modi_d;
  logic        sym_en_q, sym_en_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;

  logic [2:0]  k;
  logic [3:0]  bps;
  logic [5:0]  kmask;
  logic [19:0] q_src;
  logic [5:0]  i_bits;
  logic [5:0]  q_bits;
  logic        tick;
  logic        consume;
  logic [19:0] acc_mid;
  logic [4:0]  cnt_mid;

  assign s_ready     = (state_q == RUN) && (cnt_q <= 5'd12);
  assign busy        = (state_q == RUN);
  assign sym_data    = sym_data_q;
  assign sym_modi    = sym_modi_q;
  assign sym_en      = sym_en_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

  // Per-axis and per-symbol bit counts for the mode latched at the frame start.
  always_comb begin
    k   = 3'd0;
    bps = 4'd0;
    case (act_modi_q)
      3'd0:    begin k = 3'd1; bps = 4'd1;  end
      3'd1:    begin k = 3'd1; bps = 4'd2;  end
      3'd2:    begin k = 3'd2; bps = 4'd4;  end
      3'd3:    begin k = 3'd3; bps = 4'd6;  end
      3'd4:    begin k = 3'd4; bps = 4'd8;  end
      3'd5:    begin k = 3'd5; bps = 4'd10; end
      3'd6:    begin k = 3'd6; bps = 4'd12; end
      default: begin k = 3'd0; bps = 4'd0;  end
    endcase
  end

  // Oldest bits sit at acc[0]; I takes the first k, Q the next k (none for BPSK).
  always_comb begin
    kmask  = ~(6'h3F << k);
    q_src  = acc_q >> k;
    i_bits = acc_q[5:0] & kmask;
    q_bits = (act_modi_q == 3'd0) ? 6'd0 : (q_src[5:0] & kmask);
  end

  assign tick = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d       = state_q;
    act_modi_d    = act_modi_q;
    div_cnt_d     = div_cnt_q;
    sym_cnt_d     = sym_cnt_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    sym_data_d    = sym_data_q;
    sym_modi_d    = sym_modi_q;
    sym_en_d      = 1'b0;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
    consume       = 1'b0;
    acc_mid       = acc_q;
    cnt_mid       = cnt_q;

    case (state_q)
      IDLE: begin
        acc_d = 20'd0;
        cnt_d = 5'd0;
        if (cfg_run) begin
          act_modi_d = cfg_modi;
          div_cnt_d  = 16'd0;
          sym_cnt_d  = 16'd0;
          state_d    = RUN;
        end
      end

      RUN: begin
        div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
        if (tick) begin
          sym_en_d      = 1'b1;
          frame_start_d = (sym_cnt_q == 16'd0);
          if (act_modi_q == MODI_NULL) begin
            sym_data_d = 12'd0;
            sym_modi_d = MODI_NULL;
          end else if (cnt_q >= {1'b0, bps}) begin
            consume    = 1'b1;
            sym_data_d = {q_bits, i_bits};
            sym_modi_d = act_modi_q;
          end else begin
            sym_data_d = 12'd0;
            sym_modi_d = MODI_NULL;
            underrun_d = 1'b1;
          end
          if (sym_cnt_q == FRAME_LAST) begin
            sym_cnt_d  = 16'd0;
            act_modi_d = cfg_modi;
            if (!cfg_run) state_d = IDLE;
          end else begin
            sym_cnt_d = sym_cnt_q + 16'd1;
          end
        end

        // Same-cycle consume and accept: new byte lands above the surviving bits.
        acc_mid = consume ? (acc_q >> bps) : acc_q;
        cnt_mid = consume ? (cnt_q - {1'b0, bps}) : cnt_q;
        if (s_valid && s_ready) begin
          acc_d = acc_mid | ({12'd0, s_data} << cnt_mid);
          cnt_d = cnt_mid + 5'd8;
        end else begin
          acc_d = acc_mid;
          cnt_d = cnt_mid;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      act_modi_q    <= MODI_NULL;
      div_cnt_q     <= 16'd0;
      sym_cnt_q     <= 16'd0;
      acc_q         <= 20'd0;
      cnt_q         <= 5'd0;
      sym_data_q    <= 12'd0;
      sym_modi_q    <= MODI_NULL;
      sym_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      act_modi_q    <= act_modi_d;
      div_cnt_q     <= div_cnt_d;
      sym_cnt_q     <= sym_cnt_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sym_data_q    <= sym_data_d;
      sym_modi_q    <= sym_modi_d;
      sym_en_q      <= sym_en_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

endmodule

// File: tb/tb_qam_symbol_sched.sv
// Directed bench for qam_symbol_sched with SYM_DIV=4 and FRAME_SYMS=4; every
// expected symbol word is hand-derived from the byte stream and mode.
module tb_qam_symbol_sched;

  logic        dclk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  cfg_modi;
  logic        cfg_run;
  logic [11:0] sym_data;
  logic [2:0]  sym_modi;
  logic        sym_en;
  logic        frame_start;
  logic        underrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  qam_symbol_sched #(.SYM_DIV(4), .FRAME_SYMS(4)) dut (
    .dclk(dclk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_modi(cfg_modi), .cfg_run(cfg_run),
    .sym_data(sym_data), .sym_modi(sym_modi), .sym_en(sym_en),
    .frame_start(frame_start), .underrun(underrun), .busy(busy)
  );

  always #5 dclk = ~dclk;

  task automatic do_reset();
    rst_n    = 1'b0;
    s_data   = 8'h00;
    s_valid  = 1'b0;
    cfg_modi = 3'd0;
    cfg_run  = 1'b0;
    repeat (2) @(negedge dclk);
    rst_n = 1'b1;
    @(negedge dclk);
  endtask

  // Leaves the bench at the negedge right after the first byte was accepted.
  task automatic start_run(input logic [2:0] modi, input logic [7:0] b0);
    cfg_modi = modi;
    cfg_run  = 1'b1;
    s_valid  = 1'b1;
    s_data   = b0;
    @(negedge dclk);
    @(negedge dclk);
    s_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge dclk);
      if (sym_en === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; cfg_run = 1'b0; cfg_modi = 3'd0;
    @(negedge dclk);
    checks++; if (sym_modi !== 3'd7) begin errors++; $display("[TB] FAIL reset_modi: got %0d exp 7", sym_modi); end
    checks++; if (sym_data !== 12'h000) begin errors++; $display("[TB] FAIL reset_data: got %h exp 000", sym_data); end
    checks++; if ({s_ready, sym_en, frame_start, underrun, busy} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got %b exp 00000", {s_ready, sym_en, frame_start, underrun, busy});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge dclk);
    checks++; if ({busy, s_ready, sym_en} !== 3'b0) begin
      errors++; $display("[TB] FAIL idle_hold: got %b exp 000", {busy, s_ready, sym_en});
    end
  endtask

  task automatic test_qpsk();
    logic [11:0] exp_d [4] = '{12'h000, 12'h001, 12'h041, 12'h040};
    int n;
    do_reset();
    cfg_modi = 3'd1; cfg_run = 1'b1; s_valid = 1'b1; s_data = 8'hB4;
    @(negedge dclk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL qpsk_busy_rise: got %b exp 1", busy); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL qpsk_ready: got %b exp 1", s_ready); end
    @(negedge dclk);
    s_valid = 1'b0;
    cfg_run = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_strobe(20, n);
      checks++; if (n !== ((s == 0) ? 3 : 4)) begin errors++; $display("[TB] FAIL qpsk_spacing%0d: got %0d exp %0d", s, n, (s == 0) ? 3 : 4); end
      checks++; if (sym_data !== exp_d[s]) begin errors++; $display("[TB] FAIL qpsk_data%0d: got %h exp %h", s, sym_data, exp_d[s]); end
      checks++; if (sym_modi !== 3'd1) begin errors++; $display("[TB] FAIL qpsk_modi%0d: got %0d exp 1", s, sym_modi); end
      checks++; if (frame_start !== (s == 0)) begin errors++; $display("[TB] FAIL qpsk_fs%0d: got %b exp %b", s, frame_start, s == 0); end
      checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL qpsk_ur%0d: got %b exp 0", s, underrun); end
    end
    checks++; if ({busy, s_ready} !== 2'b00) begin errors++; $display("[TB] FAIL qpsk_stop: got %b exp 00", {busy, s_ready}); end
    @(negedge dclk);
    checks++; if (sym_en !== 1'b0) begin errors++; $display("[TB] FAIL qpsk_pulse_width: got %b exp 0", sym_en); end
    checks++; if (sym_data !== 12'h040) begin errors++; $display("[TB] FAIL qpsk_hold: got %h exp 040", sym_data); end
  endtask

  task automatic test_16qam();
    int n;
    do_reset();
    start_run(3'd2, 8'hB4);
    cfg_run = 1'b0;
    wait_strobe(20, n);
    checks++; if (n == 0) begin errors++; $display("[TB] FAIL q16_timeout0: got no strobe exp strobe"); end
    checks++; if ({sym_modi, sym_data} !== {3'd2, 12'h040}) begin errors++; $display("[TB] FAIL q16_sym0: got %0d/%h exp 2/040", sym_modi, sym_data); end
    wait_strobe(20, n);
    checks++; if ({sym_modi, sym_data} !== {3'd2, 12'h083}) begin errors++; $display("[TB] FAIL q16_sym1: got %0d/%h exp 2/083", sym_modi, sym_data); end
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b1, 3'd7, 12'h000}) begin
      errors++; $display("[TB] FAIL q16_ur2: got %b/%0d/%h exp 1/7/000", underrun, sym_modi, sym_data);
    end
    wait_strobe(20, n);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL q16_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_4096qam();
    int n;
    do_reset();
    start_run(3'd6, 8'h34);
    s_valid = 1'b1; s_data = 8'h12;
    @(negedge dclk);
    s_valid = 1'b0;
    cfg_run = 1'b0;
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b0, 3'd6, 12'h234}) begin
      errors++; $display("[TB] FAIL q4096_sym0: got %b/%0d/%h exp 0/6/234", underrun, sym_modi, sym_data);
    end
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b1, 3'd7, 12'h000}) begin
      errors++; $display("[TB] FAIL q4096_ur1: got %b/%0d/%h exp 1/7/000", underrun, sym_modi, sym_data);
    end
    s_valid = 1'b1; s_data = 8'hAB;
    @(negedge dclk);
    s_valid = 1'b0;
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b0, 3'd6, 12'hAB1}) begin
      errors++; $display("[TB] FAIL q4096_sym2: got %b/%0d/%h exp 0/6/ab1", underrun, sym_modi, sym_data);
    end
    wait_strobe(20, n);
  endtask

  task automatic test_underrun();
    int n;
    do_reset();
    start_run(3'd3, 8'hB4);
    cfg_run = 1'b0;
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b0, 3'd3, 12'h184}) begin
      errors++; $display("[TB] FAIL q64_sym0: got %b/%0d/%h exp 0/3/184", underrun, sym_modi, sym_data);
    end
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b1, 3'd7, 12'h000}) begin
      errors++; $display("[TB] FAIL q64_ur1: got %b/%0d/%h exp 1/7/000", underrun, sym_modi, sym_data);
    end
    s_valid = 1'b1; s_data = 8'h0F;
    @(negedge dclk);
    s_valid = 1'b0;
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi, sym_data} !== {1'b0, 3'd3, 12'h1C6}) begin
      errors++; $display("[TB] FAIL q64_retained: got %b/%0d/%h exp 0/3/1c6", underrun, sym_modi, sym_data);
    end
    wait_strobe(20, n);
    checks++; if (underrun !== 1'b1) begin errors++; $display("[TB] FAIL q64_ur3: got %b exp 1", underrun); end
  endtask

  task automatic test_mode_change();
    logic [11:0] exp_d [4] = '{12'h000, 12'h001, 12'h041, 12'h040};
    int n;
    do_reset();
    start_run(3'd1, 8'hB4);
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge dclk);
    s_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      wait_strobe(20, n);
      if (s == 0) cfg_modi = 3'd4;
      checks++; if ({sym_modi, sym_data} !== {3'd1, exp_d[s]}) begin
        errors++; $display("[TB] FAIL mc_sym%0d: got %0d/%h exp 1/%h", s, sym_modi, sym_data, exp_d[s]);
      end
    end
    wait_strobe(20, n);
    checks++; if ({frame_start, sym_modi, sym_data} !== {1'b1, 3'd4, 12'h14A}) begin
      errors++; $display("[TB] FAIL mc_sym4: got %b/%0d/%h exp 1/4/14a", frame_start, sym_modi, sym_data);
    end
    cfg_run = 1'b0;
    for (int s = 5; s < 8; s++) wait_strobe(20, n);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mc_busy_end: got %b exp 0", busy); end
  endtask

  task automatic test_stop();
    int n;
    do_reset();
    start_run(3'd1, 8'hB4);
    wait_strobe(20, n);
    wait_strobe(20, n);
    cfg_run = 1'b0;
    wait_strobe(20, n);
    checks++; if ({busy, sym_data} !== {1'b1, 12'h041}) begin
      errors++; $display("[TB] FAIL stop_midframe: got %b/%h exp 1/041", busy, sym_data);
    end
    wait_strobe(20, n);
    checks++; if ({n != 0, busy, s_ready} !== 3'b100) begin
      errors++; $display("[TB] FAIL stop_final: got %b exp 100", {n != 0, busy, s_ready});
    end
    wait_strobe(12, n);
    checks++; if (n !== 0) begin errors++; $display("[TB] FAIL stop_no_more: got strobe at %0d exp none", n); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    start_run(3'd2, 8'hB4);
    wait_strobe(20, n);
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({sym_modi, sym_data} !== {3'd7, 12'h000}) begin
      errors++; $display("[TB] FAIL arst_data: got %0d/%h exp 7/000", sym_modi, sym_data);
    end
    checks++; if ({sym_en, frame_start, underrun, busy, s_ready} !== 5'b0) begin
      errors++; $display("[TB] FAIL arst_flags: got %b exp 00000", {sym_en, frame_start, underrun, busy, s_ready});
    end
    @(negedge dclk);
    rst_n = 1'b1;
    cfg_modi = 3'd2; cfg_run = 1'b1;
    @(negedge dclk);
    cfg_run = 1'b0;
    wait_strobe(20, n);
    checks++; if ({underrun, sym_modi} !== {1'b1, 3'd7}) begin
      errors++; $display("[TB] FAIL arst_bits_lost: got %b/%0d exp 1/7", underrun, sym_modi);
    end
    repeat (3) wait_strobe(20, n);
  endtask

  initial begin
    test_reset();
    test_qpsk();
    test_16qam();
    test_4096qam();
    test_underrun();
    test_mode_change();
    test_stop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
